// File: rtl/par_nibble_rx.sv
// Serial nibble + parity receiver; result registered on the edge that samples the parity bit.
// Backpressure: a frame completing while the output is held (m_valid && !m_ready) is dropped and sets sticky ovr.
module par_nibble_rx #(
  parameter bit EVEN_PAR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic       s_bit,
  input  logic       frame_sync,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [3:0] m_data,
  output logic       m_perr,
  output logic       ovr,
  input  logic       ovr_clr
);

  logic [2:0] cnt;
  logic [3:0] sh;
  logic       complete;
  logic       out_free;
  logic       p;
  logic       perr;

  // A parity bit that arrives together with frame_sync is re-used as data bit 0.
  assign complete = s_valid && !frame_sync && (cnt == 3'd4);
  assign out_free = !m_valid || m_ready;
  assign p        = (^sh) ^ s_bit;
  assign perr     = EVEN_PAR ? p : ~p;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 3'd0;
      sh      <= 4'h0;
      m_valid <= 1'b0;
      m_data  <= 4'h0;
      m_perr  <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (frame_sync) begin
        sh  <= {3'b000, s_valid & s_bit};
        cnt <= s_valid ? 3'd1 : 3'd0;
      end else if (s_valid) begin
        if (cnt == 3'd4) begin
          cnt <= 3'd0;
        end else begin
          sh[cnt[1:0]] <= s_bit;
          cnt          <= cnt + 3'd1;
        end
      end

      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (complete && out_free) begin
        m_data  <= sh;
        m_perr  <= perr;
        m_valid <= 1'b1;
      end

      // Set beats clear when both happen in the same cycle.
      if (complete && !out_free) begin
        ovr <= 1'b1;
      end else if (ovr_clr) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule
